// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters,
// F/D prediction carry and decode-stage mispredict/redirect.
module branch_predict_unit #(
    parameter int IDXW = 4,
    parameter int PCW  = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PCW-1:0]  pcF,
    output logic            predtakenF,
    output logic [PCW-1:0]  targetF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            branchD,
    input  logic            takenD,
    input  logic [PCW-1:0]  pcD,
    input  logic [PCW-1:0]  targetD,
    output logic            mispredictD,
    output logic [PCW-1:0]  redirectpcD,
    output logic [CNTW-1:0] brcount,
    output logic [CNTW-1:0] misscount
);

    localparam int N    = 1 << IDXW;
    localparam int TAGW = PCW - IDXW;

    logic [N-1:0]                valid_q, valid_d;
    logic [N-1:0][TAGW-1:0]      tag_q, tag_d;
    logic [N-1:0][PCW-1:0]       tgt_q, tgt_d;
    logic [N-1:0][1:0]           ctr_q, ctr_d;
    logic                        predtaken_q, predtaken_d;
    logic [PCW-1:0]              predtarget_q, predtarget_d;
    logic [CNTW-1:0]             brcount_q, brcount_d;
    logic [CNTW-1:0]             misscount_q, misscount_d;

    logic [IDXW-1:0] idx_f, idx_d;
    logic            hit_f, hit_d;
    logic            resolve;
    logic            wrong_dir, wrong_tgt;

    // Fetch-side lookup, purely combinational from pcF
    always_comb begin
        idx_f      = pcF[IDXW-1:0];
        hit_f      = valid_q[idx_f] && (tag_q[idx_f] == pcF[PCW-1:IDXW]);
        predtakenF = hit_f & ctr_q[idx_f][1];
        targetF    = hit_f ? tgt_q[idx_f] : '0;
    end

    // Decode-side resolution and redirect selection
    always_comb begin
        idx_d     = pcD[IDXW-1:0];
        hit_d     = valid_q[idx_d] && (tag_q[idx_d] == pcD[PCW-1:IDXW]);
        resolve   = !stallD && (branchD || predtaken_q);
        wrong_dir = predtaken_q != takenD;
        wrong_tgt = takenD && (predtarget_q != targetD);
        mispredictD = resolve &&
                      ((predtaken_q && !branchD) ||
                       (branchD && (wrong_dir || wrong_tgt)));
        redirectpcD = (branchD && takenD) ? targetD
                    : pcD + {{(PCW-1){1'b0}}, 1'b1};
    end

    // F/D prediction register: flush beats stall
    always_comb begin
        predtaken_d  = predtaken_q;
        predtarget_d = predtarget_q;
        if (flushD) begin
            predtaken_d  = 1'b0;
            predtarget_d = '0;
        end else if (!stallD) begin
            predtaken_d  = predtakenF;
            predtarget_d = targetF;
        end
    end

    // Table update from the resolved instruction in D
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (resolve) begin
            if (branchD) begin
                if (hit_d) begin
                    if (takenD) begin
                        if (ctr_q[idx_d] != 2'b11)
                            ctr_d[idx_d] = ctr_q[idx_d] + 2'd1;
                        tgt_d[idx_d] = targetD;
                    end else if (ctr_q[idx_d] != 2'b00) begin
                        ctr_d[idx_d] = ctr_q[idx_d] - 2'd1;
                    end
                end else if (takenD) begin
                    valid_d[idx_d] = 1'b1;
                    tag_d[idx_d]   = pcD[PCW-1:IDXW];
                    tgt_d[idx_d]   = targetD;
                    ctr_d[idx_d]   = 2'b10;
                end
            end else begin
                // predicted-taken non-branch: drop the stale entry
                valid_d[idx_d] = 1'b0;
            end
        end
    end

    // Saturating statistics counters
    always_comb begin
        brcount_d   = brcount_q;
        misscount_d = misscount_q;
        if (resolve && branchD && !(&brcount_q))
            brcount_d = brcount_q + {{(CNTW-1){1'b0}}, 1'b1};
        if (mispredictD && !(&misscount_q))
            misscount_d = misscount_q + {{(CNTW-1){1'b0}}, 1'b1};
    end

    // Resettable state: valid bits, F/D register, counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            predtaken_q  <= 1'b0;
            predtarget_q <= '0;
            brcount_q    <= '0;
            misscount_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            predtaken_q  <= predtaken_d;
            predtarget_q <= predtarget_d;
            brcount_q    <= brcount_d;
            misscount_q  <= misscount_d;
        end
    end

    // Entry payload is meaningless while invalid, so no reset
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        ctr_q <= ctr_d;
    end

    assign brcount   = brcount_q;
    assign misscount = misscount_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plan plus random traffic
// checked against a table-level reference model.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcF, pcD, targetD;
    logic        stallD, flushD, branchD, takenD;

    logic        ptF, misD, ptF2, misD2;
    logic [31:0] tgtF, rdD, tgtF2, rdD2;
    logic [15:0] brc, msc;
    logic [1:0]  brc2, msc2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .pcF(pcF),
        .predtakenF(ptF), .targetF(tgtF),
        .stallD(stallD), .flushD(flushD),
        .branchD(branchD), .takenD(takenD),
        .pcD(pcD), .targetD(targetD),
        .mispredictD(misD), .redirectpcD(rdD),
        .brcount(brc), .misscount(msc)
    );

    branch_predict_unit #(.CNTW(2)) dut2 (
        .clk(clk), .reset(reset), .pcF(pcF),
        .predtakenF(ptF2), .targetF(tgtF2),
        .stallD(stallD), .flushD(flushD),
        .branchD(branchD), .takenD(takenD),
        .pcD(pcD), .targetD(targetD),
        .mispredictD(misD2), .redirectpcD(rdD2),
        .brcount(brc2), .misscount(msc2)
    );

    // reference model: one record per table slot
    bit          m_valid [16];
    logic [27:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_ptD;
    logic [31:0] m_ptgtD;
    int          m_br, m_miss;

    // expectations for the current cycle
    bit          e_ptF, e_res, e_mis;
    logic [31:0] e_tgtF, e_rd;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_ptD = 0; m_ptgtD = 0; m_br = 0; m_miss = 0;
    endtask

    task automatic setin(input logic [31:0] pf, input bit st,
                         input bit fl, input bit br, input bit tk,
                         input logic [31:0] pd, input logic [31:0] td);
        pcF = pf; stallD = st; flushD = fl;
        branchD = br; takenD = tk; pcD = pd; targetD = td;
        #1;
    endtask

    // derive this cycle's expectations and compare
    task automatic chk_model();
        int  fi;
        bit  hit;
        fi     = int'(pcF[3:0]);
        hit    = m_valid[fi] && m_tag[fi] == pcF[31:4];
        e_ptF  = hit && m_ctr[fi] >= 2;
        e_tgtF = hit ? m_tgt[fi] : 32'd0;
        e_res  = !stallD && (branchD || m_ptD);
        if (!e_res)       e_mis = 0;
        else if (!branchD) e_mis = 1;
        else e_mis = (m_ptD != takenD) ||
                     (takenD && m_ptgtD != targetD);
        e_rd = (branchD && takenD) ? targetD : pcD + 32'd1;
        chk("predtakenF", {31'd0, ptF}, {31'd0, e_ptF});
        chk("targetF", tgtF, e_tgtF);
        chk("mispredictD", {31'd0, misD}, {31'd0, e_mis});
        chk("redirectpcD", rdD, e_rd);
        chk("brcount", {16'd0, brc}, sat(m_br, 65535));
        chk("misscount", {16'd0, msc}, sat(m_miss, 65535));
        chk("brcount_w2", {30'd0, brc2}, sat(m_br, 3));
        chk("misscount_w2", {30'd0, msc2}, sat(m_miss, 3));
    endtask

    // clock edge: advance the model with the pre-edge decisions
    task automatic tick();
        int  di;
        bit  hit;
        @(posedge clk);
        di  = int'(pcD[3:0]);
        hit = m_valid[di] && m_tag[di] == pcD[31:4];
        if (e_res) begin
            if (branchD) begin
                m_br++;
                if (hit && takenD) begin
                    m_ctr[di] = (m_ctr[di] < 3) ? m_ctr[di] + 1 : 3;
                    m_tgt[di] = targetD;
                end else if (hit) begin
                    m_ctr[di] = (m_ctr[di] > 0) ? m_ctr[di] - 1 : 0;
                end else if (takenD) begin
                    m_valid[di] = 1;
                    m_tag[di]   = pcD[31:4];
                    m_tgt[di]   = targetD;
                    m_ctr[di]   = 2;
                end
            end else begin
                m_valid[di] = 0;
            end
        end
        if (e_mis) m_miss++;
        if (flushD) begin
            m_ptD = 0; m_ptgtD = 0;
        end else if (!stallD) begin
            m_ptD = e_ptF; m_ptgtD = e_tgtF;
        end
        #1;
    endtask

    task automatic cyc(input logic [31:0] pf, input bit st,
                       input bit fl, input bit br, input bit tk,
                       input logic [31:0] pd, input logic [31:0] td);
        setin(pf, st, fl, br, tk, pd, td);
        chk_model();
        tick();
    endtask

    initial begin
        logic [31:0] prev_pf;
        reset = 1'b1;
        model_reset();
        setin(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_model();
        reset = 1'b0;

        // first taken branch at 5 -> 9 mispredicts and allocates
        setin(5, 0, 0, 1, 1, 5, 9);
        chk_model();
        chk("plan_first_miss", {31'd0, misD}, 32'd1);
        chk("plan_first_redir", rdD, 32'd9);
        tick();
        chk("plan_misscount1", {16'd0, msc}, 32'd1);
        setin(5, 0, 0, 0, 0, 0, 0);
        chk_model();
        chk("plan_hit_pt", {31'd0, ptF}, 32'd1);
        chk("plan_hit_tgt", tgtF, 32'd9);
        tick();

        // predicted-taken in D, resolve correctly three times
        for (int i = 0; i < 3; i++) begin
            setin(5, 0, 0, 1, 1, 5, 9);
            chk_model();
            chk("plan_correct", {31'd0, misD}, 32'd0);
            tick();
        end
        chk("plan_brcount4", {16'd0, brc}, 32'd4);

        // not taken once: mispredict, redirect to fall-through
        setin(0, 0, 0, 1, 0, 5, 9);
        chk_model();
        chk("plan_nt_miss", {31'd0, misD}, 32'd1);
        chk("plan_nt_redir", rdD, 32'd6);
        tick();
        setin(5, 0, 0, 0, 0, 0, 0);
        chk_model();
        chk("plan_still_taken", {31'd0, ptF}, 32'd1);
        tick();

        // alias 21 shares slot with 5
        setin(21, 0, 0, 0, 0, 0, 0);
        chk_model();
        chk("plan_alias_miss", {31'd0, ptF}, 32'd0);
        tick();
        cyc(0, 0, 0, 1, 1, 21, 30);
        setin(5, 0, 0, 0, 0, 0, 0);
        chk_model();
        chk("plan_evicted", {31'd0, ptF}, 32'd0);
        tick();

        // stalled branch: no effect until released
        for (int i = 0; i < 3; i++) begin
            setin(0, 1, 0, 1, 1, 7, 3);
            chk_model();
            chk("plan_stall_nomis", {31'd0, misD}, 32'd0);
            tick();
        end
        cyc(0, 0, 0, 1, 1, 7, 3);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // flush beats stall; then non-branch hit invalidates
        setin(21, 1, 1, 0, 0, 0, 0);
        chk_model();
        chk("plan_flush_pt", {31'd0, ptF}, 32'd1);
        tick();
        cyc(21, 0, 0, 0, 0, 0, 0);
        setin(0, 0, 0, 0, 0, 21, 0);
        chk_model();
        chk("plan_nonbr_mis", {31'd0, misD}, 32'd1);
        chk("plan_nonbr_redir", rdD, 32'd22);
        tick();
        setin(21, 0, 0, 0, 0, 0, 0);
        chk_model();
        chk("plan_invalidated", {31'd0, ptF}, 32'd0);
        tick();

        // random traffic over a small PC window
        prev_pf = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pf, pd, td;
            pf = 32'($urandom_range(0, 47));
            pd = ($urandom_range(0, 1) == 1) ? prev_pf
                 : 32'($urandom_range(0, 47));
            td = 32'($urandom_range(0, 7)) * 8;
            cyc(pf, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 2) != 0, pd, td);
            prev_pf = pf;
        end

        // async reset while a non-branch hit is in D
        cyc(0, 0, 0, 1, 1, 40, 44);
        cyc(40, 0, 0, 0, 0, 0, 0);
        setin(40, 0, 0, 0, 0, 40, 0);
        chk_model();
        chk("plan_pre_reset_mis", {31'd0, misD}, 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_predtakenF", {31'd0, ptF}, 32'd0);
        chk("rst_targetF", tgtF, 32'd0);
        chk("rst_mispredictD", {31'd0, misD}, 32'd0);
        chk("rst_brcount", {16'd0, brc}, 32'd0);
        chk("rst_misscount", {16'd0, msc}, 32'd0);
        chk("rst_brcount_w2", {30'd0, brc2}, 32'd0);
        chk("rst_misscount_w2", {30'd0, msc2}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        setin(40, 0, 0, 0, 0, 0, 0);
        chk_model();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
